// File: rtl/sprite_arb_pkg.sv
// Shared definitions for the sprite ROM arbiter.
//   - Default values for the arbiter parameters.
//   - Requester index constants for the sprite units on the shared ROM.
//   - onehot_to_idx: converts a one-hot vector (up to 8 bits) to its bit index.
package sprite_arb_pkg;

  localparam int unsigned NumReqDef = 4;
  localparam int unsigned AddrWDef  = 12;
  localparam int unsigned DataWDef  = 12;
  localparam int unsigned RomLatDef = 1;
  localparam int unsigned MaxReq    = 8;

  localparam int unsigned REQ_GHOST_CRAZY  = 0;
  localparam int unsigned REQ_GHOST_TOP    = 1;
  localparam int unsigned REQ_GHOST_BOTTOM = 2;
  localparam int unsigned REQ_EGGS         = 3;

  // OR-reduction encoder; the result is only meaningful for a one-hot or zero input.
  function automatic logic [2:0] onehot_to_idx(input logic [MaxReq-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection (purely combinational).
//   req  in  NUM_REQ  request vector
//   ptr  in  PTR_W    index that has the highest priority this cycle
//   win  out NUM_REQ  one-hot winner, zero when req is zero
// The request vector is rotated so that ptr lands on bit 0, the lowest set bit is
// found, and the position is rotated back to an absolute requester index.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  int                   pos;
  int                   idx;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    pos   = 0;
    // Scan downward so the lowest set bit is the one that sticks.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
    idx = pos + int'(ptr);
    if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (idx == i)) win[i] = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite/colour ROM between NUM_REQ
// sprite units. One grant per clock; each grant returns a tagged result exactly
// ROM_LAT+2 cycles after the grant cycle.
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   req       in   per-requester level request, held until granted
//   addr      in   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       out  one-hot grant, combinational from req and the rr pointer
//   rom_en    out  registered ROM read enable
//   rom_addr  out  registered ROM address
//   rom_data  in   ROM read data, valid ROM_LAT cycles after rom_addr
//   rvalid    out  registered one-hot tag of the returned data (1-cycle pulse)
//   rdata     out  registered returned data, broadcast to all requesters
//   max_wait  out  (only with SPRITE_ROM_ARB_WAIT_STATS_EN) largest wait seen
// Optional feature macro: SPRITE_ROM_ARB_WAIT_STATS_EN adds per-requester
// saturating 8-bit wait counters and the max_wait output.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef,
  parameter int unsigned ADDR_W  = AddrWDef,
  parameter int unsigned DATA_W  = DataWDef,
  parameter int unsigned ROM_LAT = RomLatDef
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata
`ifdef SPRITE_ROM_ARB_WAIT_STATS_EN
  ,
  output logic [7:0]                max_wait
`endif
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] win;
  logic               any_gnt;
  logic [PtrW-1:0]    w_idx;
  logic [ADDR_W-1:0]  addr_sel;
  logic               rom_en_q;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [NUM_REQ-1:0] tag_q [ROM_LAT+1];
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0]  rdata_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win)
  );

  // No grants are visible while the block is held in reset.
  assign gnt     = reset_n ? win : '0;
  assign any_gnt = |gnt;

  always_comb begin
    w_idx      = PtrW'(onehot_to_idx(MaxReq'(gnt)));
    addr_sel   = addr[w_idx*ADDR_W +: ADDR_W];
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    if (any_gnt) begin
      ptr_d      = (w_idx == PtrW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      rom_addr_d = addr_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_en_q   <= any_gnt;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Tag stage k holds the owner of the access issued k+1 cycles ago; stage ROM_LAT
  // lines up with rom_data for that access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      tag_q[0] <= gnt;
      for (int i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      rvalid_q <= tag_q[ROM_LAT];
      if (|tag_q[ROM_LAT]) rdata_q <= rom_data;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

`ifdef SPRITE_ROM_ARB_WAIT_STATS_EN
  logic [7:0] wait_q [NUM_REQ];
  logic [7:0] wait_d [NUM_REQ];
  logic [7:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = '0;
      if (req[i] && !gnt[i]) begin
        wait_d[i] = (wait_q[i] == 8'hFF) ? 8'hFF : wait_q[i] + 8'd1;
      end
      if (wait_q[i] > max_d) max_d = wait_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
      max_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
      max_q <= max_d;
    end
  end

  assign max_wait = max_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed stimulus pushes expected
// read results into a scoreboard; a negedge monitor pops and checks them.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
`ifdef SPRITE_ROM_ARB_WAIT_STATS_EN
  logic [7:0]      max_wait;
`endif

  sprite_rom_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ROM_LAT (1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rvalid   (rvalid),
    .rdata    (rdata)
`ifdef SPRITE_ROM_ARB_WAIT_STATS_EN
    ,
    .max_wait (max_wait)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_model(input logic [AW-1:0] a);
    return {a[3:0], a[11:4]} ^ 12'h3C5;
  endfunction

  // Synchronous ROM with one cycle of latency.
  logic [DW-1:0] rom_q;
  always @(posedge clk) rom_q <= rom_model(rom_addr);
  assign rom_data = rom_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  // Check the grant of the current cycle; optionally queue its result for cycle+3.
  task automatic expect_grant(input string name, input logic [N-1:0] exp_g,
                              input logic [AW-1:0] exp_a, input bit push);
    exp_t e;
    #1;
    chk(name, 32'(gnt), 32'(exp_g));
    if (push) begin
      e.cyc  = cyc + 3;
      e.tag  = exp_g;
      e.data = rom_model(exp_a);
      sb.push_back(e);
    end
  endtask

  // Monitor: every returned result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rvalid !== '0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got %0h expected none (cycle %0d)", rvalid, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rv_cycle", 32'(cyc), 32'(e.cyc));
        chk("rv_tag", 32'(rvalid), 32'(e.tag));
        chk("rv_data", 32'(rdata), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0]  rr_tbl  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [AW-1:0] rr_addr [8] = '{12'h200, 12'h311, 12'h422, 12'h533,
                                 12'h200, 12'h311, 12'h422, 12'h533};
`ifdef SPRITE_ROM_ARB_WAIT_STATS_EN
  logic [N-1:0]  st_tbl  [8] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  logic [AW-1:0] st_addr [8] = '{12'h533, 12'h200, 12'h311, 12'h422,
                                 12'h533, 12'h200, 12'h311, 12'h422};
`endif

  initial begin
    req     = '0;
    addr    = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req = '1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rom_en", 32'(rom_en), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    req     = '0;
    reset_n = 1'b1;
    step();

    // Single request from requester 2.
    req = 4'b0100;
    set_addr(2, 12'h0A5);
    expect_grant("t1_gnt", 4'b0100, 12'h0A5, 1'b1);
    step();
    req = '0;
    #1;
    chk("t1_rom_addr", 32'(rom_addr), 32'h0A5);
    chk("t1_rom_en", 32'(rom_en), 32'h1);
    chk("t1_idle_gnt", 32'(gnt), 32'h0);
    step();
    chk("t1_rom_en_off", 32'(rom_en), 32'h0);
    chk("t1_rom_addr_hold", 32'(rom_addr), 32'h0A5);
    repeat (3) step();

    // Pointer sits at 3: grant 3, then 1001 wraps to 0, then 3 again.
    req = 4'b1000;
    set_addr(3, 12'h3F0);
    expect_grant("wrap_g3", 4'b1000, 12'h3F0, 1'b1);
    step();
    req = 4'b1001;
    set_addr(0, 12'h010);
    set_addr(3, 12'h3F1);
    expect_grant("wrap_g0", 4'b0001, 12'h010, 1'b1);
    step();
    req = 4'b1000;
    expect_grant("wrap_g3b", 4'b1000, 12'h3F1, 1'b1);
    step();
    req = '0;
    repeat (4) step();

    // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
    set_addr(0, 12'h200);
    set_addr(1, 12'h311);
    set_addr(2, 12'h422);
    set_addr(3, 12'h533);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      expect_grant($sformatf("rr_%0d", k), rr_tbl[k], rr_addr[k], 1'b1);
      step();
    end
    req = '0;
    repeat (4) step();

    // Sole requester 1, back-to-back grants with incrementing addresses.
    for (int k = 0; k < 5; k++) begin
      req = 4'b0010;
      set_addr(1, 12'h100 + 12'(k));
      expect_grant($sformatf("b2b_%0d", k), 4'b0010, 12'h100 + 12'(k), 1'b1);
      step();
    end
    req = '0;
    repeat (4) step();

    // Two grants in flight, then reset: their results must never appear.
    req = 4'b0011;
    set_addr(0, 12'h7A0);
    set_addr(1, 12'h7A1);
    expect_grant("prerst_g0", 4'b0001, 12'h7A0, 1'b0);
    step();
    expect_grant("prerst_g1", 4'b0010, 12'h7A1, 1'b0);
    step();
    reset_n = 1'b0;
    req     = 4'b0110;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    step();
    reset_n = 1'b1;
    req     = '0;
    repeat (4) begin
      step();
      chk("postrst_rvalid", 32'(rvalid), 32'h0);
    end
    // Pointer back at 0, so 0110 grants 1 first (it would be 2 with the old pointer).
    req = 4'b0110;
    set_addr(1, 12'h055);
    set_addr(2, 12'h0AA);
    expect_grant("postrst_g1", 4'b0010, 12'h055, 1'b1);
    step();
    req = 4'b0100;
    expect_grant("postrst_g2", 4'b0100, 12'h0AA, 1'b1);
    step();
    req = '0;
    repeat (4) step();

`ifdef SPRITE_ROM_ARB_WAIT_STATS_EN
    // Pointer at 3; with everyone requesting the longest wait is 3 cycles.
    set_addr(0, 12'h200);
    set_addr(1, 12'h311);
    set_addr(2, 12'h422);
    set_addr(3, 12'h533);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      expect_grant($sformatf("st_%0d", k), st_tbl[k], st_addr[k], 1'b1);
      step();
    end
    req = '0;
    repeat (4) step();
    chk("max_wait", 32'(max_wait), 32'd3);
`endif

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
